// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel position, VGA syncs, blanking qualifier and per-frame game tick.
// Define VGA_SYNC_PIXDIV_EN to advance the raster every second clk (50 MHz clock, 25 MHz pixel rate).
module vga_sync_gen #(
   parameter int unsigned H_VISIBLE = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_VISIBLE = 480,
   parameter int unsigned V_FRONT   = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33,
   parameter logic        SYNC_POL  = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   output logic [9:0] col,
   output logic [9:0] row,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic       tick,
   output logic       pix_en
);

   localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0]  V_TICK   = 10'(V_VISIBLE);
   // Window bounds are 11 bits so an end value of 1024 still compares correctly.
   localparam logic [10:0] H_VIS_END = 11'(H_VISIBLE);
   localparam logic [10:0] V_VIS_END = 11'(V_VISIBLE);
   localparam logic [10:0] HS_START  = 11'(H_VISIBLE + H_FRONT);
   localparam logic [10:0] HS_END    = 11'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [10:0] VS_START  = 11'(V_VISIBLE + V_FRONT);
   localparam logic [10:0] VS_END    = 11'(V_VISIBLE + V_FRONT + V_SYNC);

   logic       adv;
   logic [9:0] col_nxt;
   logic [9:0] row_nxt;
   logic       hs_act;
   logic       vs_act;

`ifdef VGA_SYNC_PIXDIV_EN
   logic toggle;

   always_ff @(posedge clk) begin
      if (reset)
         toggle <= 1'b0;
      else
         toggle <= ~toggle;
   end

   assign adv    = toggle;
   assign pix_en = toggle;
`else
   assign adv    = 1'b1;
   assign pix_en = 1'b1;
`endif

   always_comb begin
      col_nxt = col;
      row_nxt = row;
      if (adv) begin
         if (col == H_LAST) begin
            col_nxt = 10'd0;
            row_nxt = (row == V_LAST) ? 10'd0 : row + 10'd1;
         end else begin
            col_nxt = col + 10'd1;
         end
      end
   end

   assign hs_act = ({1'b0, col_nxt} >= HS_START) && ({1'b0, col_nxt} < HS_END);
   assign vs_act = ({1'b0, row_nxt} >= VS_START) && ({1'b0, row_nxt} < VS_END);

   // Outputs are derived from the next-state position so they line up with row/col.
   always_ff @(posedge clk) begin
      if (reset) begin
         col      <= H_LAST;
         row      <= V_LAST;
         hsync    <= ~SYNC_POL;
         vsync    <= ~SYNC_POL;
         video_on <= 1'b0;
         tick     <= 1'b0;
      end else begin
         col      <= col_nxt;
         row      <= row_nxt;
         hsync    <= hs_act ? SYNC_POL : ~SYNC_POL;
         vsync    <= vs_act ? SYNC_POL : ~SYNC_POL;
         video_on <= ({1'b0, col_nxt} < H_VIS_END) && ({1'b0, row_nxt} < V_VIS_END);
         tick     <= adv && (col_nxt == 10'd0) && (row_nxt == V_TICK);
      end
   end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen on a reduced raster (32x19) with a position-index reference model.
module tb_vga_sync_gen;

   localparam int HV = 20, HF = 3, HS = 5, HB = 4;
   localparam int VV = 12, VF = 2, VS = 2, VB = 3;
   localparam int HT = HV + HF + HS + HB;
   localparam int VT = VV + VF + VS + VB;
   localparam int FRAME = HT * VT;
   localparam logic SP = 1'b0;
`ifdef VGA_SYNC_PIXDIV_EN
   localparam int DIV = 2;
`else
   localparam int DIV = 1;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [9:0] col, row;
   logic       hsync, vsync, video_on, tick, pix_en;

   vga_sync_gen #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .SYNC_POL(SP)
   ) dut (
      .clk(clk), .reset(reset), .col(col), .row(row), .hsync(hsync),
      .vsync(vsync), .video_on(video_on), .tick(tick), .pix_en(pix_en)
   );

   always #5 clk = ~clk;

   typedef struct {
      int col;
      int row;
      bit hs;
      bit vs;
      bit von;
      bit tk;
      bit pe;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model: raster position as a single index into the frame.
   int m_pos = FRAME - 1;
   bit m_tog = 1'b0;
   bit m_tick = 1'b0;

   bit agg_en = 1'b0;
   int cnt_von = 0, cnt_tick = 0, cnt_hs = 0, cnt_vs = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic push_exp(input bit r);
      exp_t e;
      int   c, rw;
      bit   adv;
      if (r) begin
         m_pos  = FRAME - 1;
         m_tog  = 1'b0;
         m_tick = 1'b0;
      end else begin
         adv    = (DIV == 1) ? 1'b1 : m_tog;
         m_tog  = (DIV == 1) ? 1'b0 : ~m_tog;
         m_tick = 1'b0;
         if (adv) begin
            m_pos  = (m_pos + 1) % FRAME;
            m_tick = (m_pos == VV * HT);
         end
      end
      c  = m_pos % HT;
      rw = m_pos / HT;
      e.col = c;
      e.row = rw;
      e.hs  = (c >= HV + HF && c < HV + HF + HS) ? SP : ~SP;
      e.vs  = (rw >= VV + VF && rw < VV + VF + VS) ? SP : ~SP;
      e.von = (c < HV) && (rw < VV);
      e.tk  = m_tick;
      e.pe  = (DIV == 1) ? 1'b1 : m_tog;
      q.push_back(e);
   endtask

   task automatic drive(input bit r);
      @(posedge clk);
      #1;
      reset = r;
      push_exp(r);
   endtask

   // Monitor: one expected entry per clk edge, compared mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #3;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("col", int'(col), e.col);
            chk("row", int'(row), e.row);
            chk("hsync", int'(hsync), int'(e.hs));
            chk("vsync", int'(vsync), int'(e.vs));
            chk("video_on", int'(video_on), int'(e.von));
            chk("tick", int'(tick), int'(e.tk));
            chk("pix_en", int'(pix_en), int'(e.pe));
            if (agg_en) begin
               cnt_von  += int'(video_on);
               cnt_tick += int'(tick);
               cnt_hs   += int'(hsync == SP);
               cnt_vs   += int'(vsync == SP);
            end
         end
      end
   end

   initial begin
      int  target;
      bit  found;
      reset = 1'b1;
      push_exp(1'b1);
      drive(1'b1);
      drive(1'b1);
      drive(1'b0);

      // Two whole frames without reset: totals are fixed by the timing arithmetic.
      for (int i = 0; i < 37; i++) drive(1'b0);
      agg_en = 1'b1;
      for (int i = 0; i < 2 * FRAME * DIV; i++) drive(1'b0);
      agg_en = 1'b0;
      chk("frame_video_on_cycles", cnt_von, 2 * HV * VV * DIV);
      chk("frame_tick_count", cnt_tick, 2);
      chk("frame_hsync_active_cycles", cnt_hs, 2 * VT * HS * DIV);
      chk("frame_vsync_active_cycles", cnt_vs, 2 * VS * HT * DIV);

      // Mid-frame reset at a chosen visible pixel.
      target = 5 * HT + 10;
      found  = 1'b0;
      for (int i = 0; i < 2 * FRAME * DIV && !found; i++) begin
         drive(1'b0);
         found = (m_pos == target);
      end
      chk("midframe_position_reached", int'(found), 1);
      drive(1'b1);
      for (int i = 0; i < 2 * HT * DIV; i++) drive(1'b0);

      // Random reset pulses of random length across several frames.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 399) == 0) begin
            for (int k = 0; k < int'($urandom_range(1, 3)); k++) drive(1'b1);
         end else begin
            drive(1'b0);
         end
      end

      @(posedge clk);
      #5;
      chk("scoreboard_drained", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
